// File: rtl/dump_monitor.sv
// Receive-side checker for the generator's dump_on pulse: armed by state_start,
// measures the pulse high time and reports completion or missing/short/stuck errors.
`timescale 1ns/1ps
module dump_monitor #(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 500,
    parameter int MIN_W    = 10,
    parameter int MAX_W    = 1000
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             state_start,
    input  logic             dump_on,
    output logic             busy,
    output logic             dump_done,
    output logic [CNT_W-1:0] dump_width,
    output logic             dump_err,
    output logic [1:0]       err_code
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_ACTIVE = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_WAIT_LAST = CNT_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] C_MIN_W     = CNT_W'(MIN_W);
    localparam logic [CNT_W-1:0] C_MAX_LAST  = CNT_W'(MAX_W - 1);
    localparam logic [CNT_W-1:0] C_MAX_W     = CNT_W'(MAX_W);
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_ZERO      = CNT_W'(0);

    localparam logic [1:0] E_NONE    = 2'b00;
    localparam logic [1:0] E_MISSING = 2'b01;
    localparam logic [1:0] E_SHORT   = 2'b10;
    localparam logic [1:0] E_STUCK   = 2'b11;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ss_d;
    logic             r_don_d;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_width;
    logic             r_err;
    logic [1:0]       r_code;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic [CNT_W-1:0] w_width_nxt;
    logic             w_err_nxt;
    logic [1:0]       w_code_nxt;
    logic             w_ss_rise;
    logic             w_don_rise;
    logic             w_don_fall;

    assign w_ss_rise  = state_start & ~r_ss_d;
    assign w_don_rise = dump_on & ~r_don_d;
    assign w_don_fall = ~dump_on & r_don_d;

    // Next-state, counter and output decode; a dump_on rise outranks the missing-pulse timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_width_nxt = r_width;
        w_err_nxt   = r_err;
        w_code_nxt  = r_code;
        case (r_state)
            S_IDLE, S_ERR: begin
                if (w_ss_rise) begin
                    w_state_nxt = S_ARMED;
                    w_cnt_nxt   = C_ZERO;
                    w_err_nxt   = 1'b0;
                    w_code_nxt  = E_NONE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_ARMED: begin
                if (w_don_rise) begin
                    w_state_nxt = S_ACTIVE;
                    w_cnt_nxt   = C_ONE;
                end else if (r_cnt == C_WAIT_LAST) begin
                    w_state_nxt = S_ERR;
                    w_err_nxt   = 1'b1;
                    w_code_nxt  = E_MISSING;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            S_ACTIVE: begin
                if (w_don_fall) begin
                    w_width_nxt = r_cnt;
                    if (r_cnt >= C_MIN_W) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = 1'b1;
                        w_code_nxt  = E_SHORT;
                    end
                end else if (dump_on) begin
                    w_cnt_nxt = r_cnt + C_ONE;
                    if (r_cnt == C_MAX_LAST) begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = 1'b1;
                        w_code_nxt  = E_STUCK;
                        w_width_nxt = C_MAX_W;
                    end else begin
                        w_state_nxt = S_ACTIVE;
                    end
                end else begin
                    w_state_nxt = S_ACTIVE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt == S_ARMED) || (w_state_nxt == S_ACTIVE);
    end

    // State, counter, edge-detect and output registers with synchronous active-low reset.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= C_ZERO;
            r_ss_d  <= 1'b0;
            r_don_d <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_width <= C_ZERO;
            r_err   <= 1'b0;
            r_code  <= E_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ss_d  <= state_start;
            r_don_d <= dump_on;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_width <= w_width_nxt;
            r_err   <= w_err_nxt;
            r_code  <= w_code_nxt;
        end
    end

    assign busy       = r_busy;
    assign dump_done  = r_done;
    assign dump_width = r_width;
    assign dump_err   = r_err;
    assign err_code   = r_code;

endmodule

// File: tb/tb_dump_monitor.sv
// Directed bench for dump_monitor: a vector table for reset and short/minimum
// pulses, plus hand-written sequences for timeout, stuck, tie and mid-pulse reset.
`timescale 1ns/1ps
module tb_dump_monitor;

    logic        clk_sys;
    logic        rst_n;
    logic        state_start;
    logic        dump_on;
    logic        busy;
    logic        dump_done;
    logic [15:0] dump_width;
    logic        dump_err;
    logic [1:0]  err_code;

    int n_cmp = 0;
    int n_mis = 0;
    int n_done = 0;
    logic both_seen = 1'b0;

    typedef struct {
        logic        rst_n;
        logic        ss;
        logic        don;
        int          n;
        logic        busy;
        logic        done;
        logic        err;
        logic [1:0]  code;
        logic [15:0] width;
    } vec_t;

    vec_t vt[$];

    dump_monitor #(.CNT_W(16), .WAIT_MAX(500), .MIN_W(10), .MAX_W(1000)) u_dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .state_start (state_start),
        .dump_on     (dump_on),
        .busy        (busy),
        .dump_done   (dump_done),
        .dump_width  (dump_width),
        .dump_err    (dump_err),
        .err_code    (err_code)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic cycle();
        @(posedge clk_sys);
        #1;
        if (dump_done) n_done++;
        if (dump_done && dump_err) both_seen = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic d, input int n,
                       input logic b, input logic dn, input logic e,
                       input logic [1:0] c, input logic [15:0] w);
        vec_t v;
        v.rst_n = r; v.ss = s; v.don = d; v.n = n;
        v.busy = b; v.done = dn; v.err = e; v.code = c; v.width = w;
        vt.push_back(v);
    endtask

    task automatic chk_all(input string tag, input logic b, input logic dn, input logic e,
                           input logic [1:0] c, input logic [15:0] w);
        chk({tag, " busy"},  32'(busy),       32'(b));
        chk({tag, " done"},  32'(dump_done),  32'(dn));
        chk({tag, " err"},   32'(dump_err),   32'(e));
        chk({tag, " code"},  32'(err_code),   32'(c));
        chk({tag, " width"}, 32'(dump_width), 32'(w));
    endtask

    initial begin
        int k;
        logic bad;
        rst_n = 1'b0; state_start = 1'b0; dump_on = 1'b0;

        // Reset held 10 clocks with dump_on toggling.
        for (int i = 0; i < 10; i++) add(1'b0, 1'b0, (i % 2 == 0), 1, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0);
        add(1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0);
        // Run 1: 9-cycle pulse -> short.
        add(1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 2'b00, 16'd0);
        add(1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 2'b00, 16'd0);
        add(1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 2'b00, 16'd0);
        add(1'b1, 1'b0, 1'b1, 8, 1'b1, 1'b0, 1'b0, 2'b00, 16'd0);
        add(1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 2'b10, 16'd9);
        add(1'b1, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b1, 2'b10, 16'd9);
        // Run 2: re-arm clears the error; 10-cycle pulse with an ignored ss rise mid-pulse.
        add(1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 2'b00, 16'd9);
        add(1'b1, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0, 2'b00, 16'd9);
        add(1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 2'b00, 16'd9);
        add(1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0, 2'b00, 16'd9);
        add(1'b1, 1'b0, 1'b1, 8, 1'b1, 1'b0, 1'b0, 2'b00, 16'd9);
        add(1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 2'b00, 16'd10);
        add(1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 2'b00, 16'd10);

        for (int i = 0; i < vt.size(); i++) begin
            rst_n = vt[i].rst_n; state_start = vt[i].ss; dump_on = vt[i].don;
            repeat (vt[i].n) cycle();
            chk_all($sformatf("vec%0d", i), vt[i].busy, vt[i].done, vt[i].err, vt[i].code, vt[i].width);
        end

        // Legal 100-cycle pulse rising 5 cycles after arm.
        n_done = 0; bad = 1'b0;
        state_start = 1'b1; cycle();
        state_start = 1'b0;
        repeat (4) begin cycle(); if (!busy) bad = 1'b1; end
        dump_on = 1'b1;
        repeat (100) begin cycle(); if (!busy) bad = 1'b1; end
        chk("legal busy held", 32'(bad), 32'd0);
        dump_on = 1'b0; cycle();
        chk_all("legal end", 1'b0, 1'b1, 1'b0, 2'b00, 16'd100);
        cycle();
        chk("legal single done", 32'(n_done), 32'd1);

        // Missing pulse: error exactly 500 cycles after arm.
        n_done = 0;
        state_start = 1'b1; cycle();
        state_start = 1'b0; k = 0;
        while (!dump_err && k < 600) begin cycle(); k++; end
        chk("missing latency", 32'(k), 32'd500);
        chk_all("missing", 1'b0, 1'b0, 1'b1, 2'b01, 16'd100);
        chk("missing no done", 32'(n_done), 32'd0);

        // Rise coincides with the timeout cycle: rise wins.
        state_start = 1'b1; cycle();
        state_start = 1'b0;
        repeat (499) cycle();
        chk_all("tie pre", 1'b1, 1'b0, 1'b0, 2'b00, 16'd100);
        dump_on = 1'b1; cycle();
        chk_all("tie rise", 1'b1, 1'b0, 1'b0, 2'b00, 16'd100);
        repeat (9) cycle();
        dump_on = 1'b0; cycle();
        chk_all("tie end", 1'b0, 1'b1, 1'b0, 2'b00, 16'd10);

        // dump_on already high at arm is not a rise: timeout applies.
        dump_on = 1'b1; cycle();
        state_start = 1'b1; cycle();
        state_start = 1'b0; k = 0;
        while (!dump_err && k < 600) begin cycle(); k++; end
        chk("high-at-arm latency", 32'(k), 32'd500);
        chk("high-at-arm code", 32'(err_code), 32'd1);

        // Stuck pulse: error when the count reaches 1000, then re-arm clears it.
        dump_on = 1'b0; state_start = 1'b1; cycle();
        chk_all("stuck arm", 1'b1, 1'b0, 1'b0, 2'b00, 16'd10);
        state_start = 1'b0; dump_on = 1'b1; cycle();
        k = 0;
        while (!dump_err && k < 1200) begin cycle(); k++; end
        chk("stuck latency", 32'(k), 32'd999);
        chk_all("stuck", 1'b0, 1'b0, 1'b1, 2'b11, 16'd1000);
        repeat (1000) cycle();
        chk_all("stuck hold", 1'b0, 1'b0, 1'b1, 2'b11, 16'd1000);
        dump_on = 1'b0; cycle();
        state_start = 1'b1; cycle();
        chk_all("stuck rearm", 1'b1, 1'b0, 1'b0, 2'b00, 16'd1000);

        // Reset mid-pulse, then a clean 20-cycle pulse.
        state_start = 1'b0; dump_on = 1'b1; cycle();
        repeat (48) cycle();
        rst_n = 1'b0; cycle();
        chk_all("midreset", 1'b0, 1'b0, 1'b0, 2'b00, 16'd0);
        rst_n = 1'b1; dump_on = 1'b0; cycle();
        n_done = 0;
        state_start = 1'b1; cycle();
        state_start = 1'b0; dump_on = 1'b1;
        repeat (20) cycle();
        dump_on = 1'b0; cycle();
        chk_all("post-reset end", 1'b0, 1'b1, 1'b0, 2'b00, 16'd20);
        cycle();
        chk("post-reset single done", 32'(n_done), 32'd1);
        chk("done with err never", 32'(both_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
